// File: rtl/mrd_pp_sched.sv
// Ping-pong packet scheduler across two memory engines with an in-order output FIFO.
// Optional inter-beat timeout/abort is enabled by defining MRD_PP_TIMEOUT_EN.
module mrd_pp_sched #(
  parameter int unsigned TO_CYC = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_sop,
  input  logic       in_eop,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] eng_sink_ready,
  output logic [1:0] eng_sop,
  output logic [1:0] eng_valid,
  output logic [1:0] eng_abort,
  input  logic [1:0] eng_src_valid,
  input  logic [1:0] eng_src_eop,
  output logic       out_sel,
  output logic       out_valid,
  output logic       err_order
);

`ifdef MRD_PP_TIMEOUT_EN
  typedef enum logic [1:0] {StIdle, StPass, StAbort} state_e;
`else
  typedef enum logic [1:0] {StIdle, StPass} state_e;
`endif

  state_e     state_q, state_d;
  logic       sel_q, last_sel_q;
  logic [1:0] fifo_q;
  logic       wr_ptr_q, rd_ptr_q;
  logic [1:0] count_q;
  logic       out_sel_q, err_q;

  logic       pick, target, accept;
  logic       head, head_vld, pop, drop, in_abort, err_set;
  logic [1:0] head_mask;

  // Both ready alternates; otherwise the single ready engine wins.
  assign pick     = (&eng_sink_ready) ? ~last_sel_q : eng_sink_ready[1];
  assign head_vld = (count_q != 2'd0);
  assign head     = fifo_q[rd_ptr_q];
  assign pop      = head_vld & eng_src_valid[head] & eng_src_eop[head];
  assign accept   = (state_q == StIdle) & in_sop & in_valid & in_ready;
  assign target   = (state_q == StIdle) ? pick : sel_q;

  assign head_mask = head_vld ? (head ? 2'b10 : 2'b01) : 2'b00;
  assign err_set   = |(eng_src_valid & ~head_mask);

`ifdef MRD_PP_TIMEOUT_EN
  localparam int unsigned GapW = $clog2(TO_CYC + 1);

  logic [GapW-1:0] gap_q, gap_d;
  logic            gap_hit;

  assign gap_hit  = (gap_q == GapW'(TO_CYC));
  assign in_abort = (state_q == StAbort);

  always_comb begin
    gap_d = '0;
    if (state_q == StPass) begin
      if (in_valid)      gap_d = '0;
      else if (!gap_hit) gap_d = gap_q + GapW'(1);
      else               gap_d = gap_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) gap_q <= '0;
    else        gap_q <= gap_d;
  end
`else
  logic unused_to_cyc;
  assign unused_to_cyc = ^TO_CYC;
  assign in_abort      = 1'b0;
`endif

  // Aborted packet is always the tail; never retract past an entry popped this cycle.
  assign drop = in_abort & (count_q > {1'b0, pop});

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: if (accept) state_d = StPass;
      StPass: begin
        if (in_valid && in_eop) state_d = StIdle;
`ifdef MRD_PP_TIMEOUT_EN
        else if (!in_valid && gap_hit) state_d = StAbort;
`endif
      end
`ifdef MRD_PP_TIMEOUT_EN
      StAbort: state_d = StIdle;
`endif
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    eng_abort = 2'b00;
    if (rst_n) begin
      case (state_q)
        StIdle: in_ready = (eng_sink_ready != 2'b00) && (count_q < 2'd2);
        StPass: in_ready = 1'b1;
`ifdef MRD_PP_TIMEOUT_EN
        StAbort: eng_abort[sel_q] = 1'b1;
`endif
        default: in_ready = 1'b0;
      endcase
    end
    eng_valid = 2'b00;
    if (in_valid && in_ready) eng_valid[target] = 1'b1;
    eng_sop   = in_sop ? eng_valid : 2'b00;
    out_valid = rst_n & head_vld & eng_src_valid[head];
    out_sel   = head_vld ? head : out_sel_q;
    err_order = err_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel_q      <= 1'b0;
      last_sel_q <= 1'b1;
      fifo_q     <= 2'b00;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
      out_sel_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      if (accept) begin
        sel_q            <= pick;
        last_sel_q       <= pick;
        fifo_q[wr_ptr_q] <= pick;
      end
      // accept (IDLE) and drop (ABORT) are mutually exclusive
      wr_ptr_q  <= wr_ptr_q ^ (accept | drop);
      rd_ptr_q  <= rd_ptr_q ^ pop;
      count_q   <= count_q + {1'b0, accept} - {1'b0, pop} - {1'b0, drop};
      out_sel_q <= out_sel;
      err_q     <= err_q | err_set;
    end
  end

endmodule

// File: tb/tb_mrd_pp_sched.sv
// Scoreboard bench for mrd_pp_sched: a transaction-level model predicts every cycle's
// outputs into a queue that a negedge monitor pops and compares.
module tb_mrd_pp_sched;
  localparam int unsigned ToCyc = 16;
`ifdef MRD_PP_TIMEOUT_EN
  localparam bit TimeoutEn = 1'b1;
`else
  localparam bit TimeoutEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_sop = 1'b0, in_eop = 1'b0, in_valid = 1'b0, in_ready;
  logic [1:0] eng_sink_ready = 2'b00, eng_sop, eng_valid, eng_abort;
  logic [1:0] eng_src_valid = 2'b00, eng_src_eop = 2'b00;
  logic       out_sel, out_valid, err_order;

  always #5 clk = ~clk;

  mrd_pp_sched #(.TO_CYC(ToCyc)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_sop         (in_sop),
    .in_eop         (in_eop),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .eng_sink_ready (eng_sink_ready),
    .eng_sop        (eng_sop),
    .eng_valid      (eng_valid),
    .eng_abort      (eng_abort),
    .eng_src_valid  (eng_src_valid),
    .eng_src_eop    (eng_src_eop),
    .out_sel        (out_sel),
    .out_valid      (out_valid),
    .err_order      (err_order)
  );

  typedef struct {
    bit       rst;
    bit       rdy;
    bit [1:0] v;
    bit [1:0] s;
    bit [1:0] ab;
    bit       ov;
    bit       os;
    bit       err;
  } exp_t;

  typedef struct {
    bit eng;
    bit done;
  } ent_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   abort_cnt = 0;
  logic last_sop_eng = 1'b0;

  // Model: packet phase (0 idle, 1 in packet, 2 abort), arbitration memory, order list.
  int   m_st = 0;
  bit   m_sel = 1'b0, m_last = 1'b1, m_lastout = 1'b0, m_err = 1'b0;
  int   m_gap = 0;
  ent_t m_ord[$];
  bit   last_acc = 1'b0;

  bit       n_rst = 1'b0, n_sop = 1'b0, n_eop = 1'b0, n_val = 1'b0;
  bit [1:0] n_sink = 2'b00, n_sv = 2'b00, n_se = 2'b00;

  task automatic chk(string name, logic [1:0] act, logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    exp_t e;
    ent_t t;
    bit   hv, hd, pk, tgt, pop, acc;
    @(posedge clk);
    #1;
    rst_n = n_rst; in_sop = n_sop; in_eop = n_eop; in_valid = n_val;
    eng_sink_ready = n_sink; eng_src_valid = n_sv; eng_src_eop = n_se;
    e.rst = 1'b0; e.rdy = 1'b0; e.v = 2'b00; e.s = 2'b00; e.ab = 2'b00;
    e.ov = 1'b0; e.os = 1'b0; e.err = 1'b0;
    if (!n_rst) begin
      e.rst = 1'b1;
      exp_q.push_back(e);
      m_st = 0; m_sel = 1'b0; m_last = 1'b1; m_lastout = 1'b0; m_err = 1'b0; m_gap = 0;
      m_ord.delete();
      last_acc = 1'b0;
      return;
    end
    hv  = (m_ord.size() > 0);
    hd  = hv ? m_ord[0].eng : 1'b0;
    pk  = (n_sink == 2'b11) ? !m_last : n_sink[1];
    e.rdy = (m_st == 1) ? 1'b1 : (m_st == 2) ? 1'b0 : (n_sink != 2'b00 && m_ord.size() < 2);
    tgt = (m_st == 0) ? pk : m_sel;
    if (n_val && e.rdy) e.v[tgt] = 1'b1;
    e.s = n_sop ? e.v : 2'b00;
    if (m_st == 2) e.ab[m_sel] = 1'b1;
    e.ov  = hv && n_sv[hd];
    e.os  = hv ? hd : m_lastout;
    e.err = m_err;
    exp_q.push_back(e);

    m_lastout = e.os;
    for (int k = 0; k < 2; k++) if (n_sv[k] && !(hv && hd == k[0])) m_err = 1'b1;
    pop = hv && n_sv[hd] && n_se[hd];
    acc = (m_st == 0) && n_sop && n_val && e.rdy;
    last_acc = acc;
    if (pop) void'(m_ord.pop_front());
    case (m_st)
      0: if (acc) begin
        t.eng = pk; t.done = 1'b0;
        m_ord.push_back(t);
        m_sel = pk; m_last = pk; m_st = 1; m_gap = 0;
      end
      1: if (n_val) begin
        m_gap = 0;
        if (n_eop) begin
          t = m_ord.pop_back(); t.done = 1'b1; m_ord.push_back(t);
          m_st = 0;
        end
      end else begin
        if (TimeoutEn && m_gap >= ToCyc) m_st = 2;
        else if (m_gap < ToCyc) m_gap++;
      end
      default: begin
        if (m_ord.size() > 0) void'(m_ord.pop_back());
        m_st = 0;
      end
    endcase
  endtask

  task automatic idle_inputs();
    n_sop = 1'b0; n_eop = 1'b0; n_val = 1'b0; n_sv = 2'b00; n_se = 2'b00;
  endtask

  // Retries sop until accepted; after a few refused cycles the finished head is drained.
  task automatic send_pkt(int len, bit [1:0] sink);
    int w = 0;
    do begin
      idle_inputs(); n_sink = sink; n_sop = 1'b1; n_val = 1'b1;
      if (w >= 4 && m_ord.size() > 0 && m_ord[0].done) begin
        n_sv[m_ord[0].eng] = 1'b1; n_se[m_ord[0].eng] = 1'b1;
      end
      step();
      w++;
    end while (!last_acc && w < 200);
    if (!last_acc) begin
      checks++; errors++;
      $display("FAIL accept_wait: no acceptance after %0d cycles, required one", w);
      idle_inputs();
      return;
    end
    for (int i = 1; i < len; i++) begin
      idle_inputs(); n_sink = sink; n_val = 1'b1; n_eop = (i == len - 1);
      step();
    end
    idle_inputs();
  endtask

  task automatic drain_all();
    int w = 0;
    while (m_ord.size() > 0 && w < 60) begin
      idle_inputs();
      if (m_ord[0].done) begin
        n_sv[m_ord[0].eng] = 1'b1; n_se[m_ord[0].eng] = 1'b1;
      end
      step();
      w++;
    end
    idle_inputs();
    step();
  endtask

  task automatic do_reset(int cycles);
    idle_inputs(); n_rst = 1'b0;
    for (int i = 0; i < cycles; i++) step();
    n_rst = 1'b1;
  endtask

  task automatic sample_now();
    @(negedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (eng_abort != 2'b00) abort_cnt++;
    if (eng_sop != 2'b00) last_sop_eng = eng_sop[1];
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("in_ready", {1'b0, in_ready}, {1'b0, mon_e.rdy});
      chk("eng_valid", eng_valid, mon_e.v);
      chk("eng_sop", eng_sop, mon_e.s);
      chk("eng_abort", eng_abort, mon_e.ab);
      chk("out_valid", {1'b0, out_valid}, {1'b0, mon_e.ov});
      if (!mon_e.rst) begin
        chk("out_sel", {1'b0, out_sel}, {1'b0, mon_e.os});
        chk("err_order", {1'b0, err_order}, {1'b0, mon_e.err});
      end
    end
  end

  initial begin
    int h_left;
    n_sink = 2'b11;
    do_reset(2);
    idle_inputs(); step();
    sample_now();
    chk("reset_out_sel", {1'b0, out_sel}, 2'b00);
    chk("reset_err", {1'b0, err_order}, 2'b00);

    // Three back-to-back packets, both engines ready: 0, 1, then 0 once engine 0 drains.
    send_pkt(8, 2'b11); sample_now(); chk("bb_pkt1_eng", {1'b0, last_sop_eng}, 2'b00);
    send_pkt(8, 2'b11); sample_now(); chk("bb_pkt2_eng", {1'b0, last_sop_eng}, 2'b01);
    send_pkt(8, 2'b11); sample_now(); chk("bb_pkt3_eng", {1'b0, last_sop_eng}, 2'b00);
    drain_all();

    // Only engine 1 ready at sop.
    send_pkt(4, 2'b10); sample_now(); chk("only1_eng", {1'b0, last_sop_eng}, 2'b01);
    drain_all();

    // Out-of-order source valid from engine 1 while engine 0 is head.
    send_pkt(3, 2'b11);
    send_pkt(3, 2'b11);
    idle_inputs(); n_sv = 2'b10; step();
    idle_inputs(); n_sv = 2'b01; n_se = 2'b01; step();
    idle_inputs(); step();
    sample_now();
    chk("ooo_err", {1'b0, err_order}, 2'b01);
    chk("ooo_next_head", {1'b0, out_sel}, 2'b01);
    drain_all();
    do_reset(1);
    idle_inputs(); step();

    // Push and pop in the same cycle with one entry queued.
    send_pkt(3, 2'b11);
    idle_inputs(); n_sink = 2'b11; n_sop = 1'b1; n_val = 1'b1;
    n_sv[m_ord[0].eng] = 1'b1; n_se[m_ord[0].eng] = 1'b1;
    step();
    for (int i = 0; i < 2; i++) begin
      idle_inputs(); n_val = 1'b1; n_eop = (i == 1); step();
    end
    sample_now();
    chk("pushpop_head", {1'b0, out_sel}, {1'b0, last_sop_eng});
    drain_all();

    // Inter-beat gap longer than the timeout.
    abort_cnt = 0;
    idle_inputs(); n_sink = 2'b11; n_sop = 1'b1; n_val = 1'b1; step();
    for (int i = 0; i < 3; i++) begin idle_inputs(); n_val = 1'b1; step(); end
    for (int i = 0; i < 40; i++) begin idle_inputs(); step(); end
    if (!TimeoutEn) begin idle_inputs(); n_val = 1'b1; n_eop = 1'b1; step(); end
    idle_inputs(); step();
    sample_now();
    chk("abort_pulses", abort_cnt[1:0], {1'b0, TimeoutEn});
    drain_all();

    // Reset in the middle of a packet.
    abort_cnt = 0;
    idle_inputs(); n_sink = 2'b11; n_sop = 1'b1; n_val = 1'b1; step();
    for (int i = 0; i < 2; i++) begin idle_inputs(); n_val = 1'b1; step(); end
    do_reset(1);
    send_pkt(3, 2'b11); sample_now();
    chk("post_reset_eng", {1'b0, last_sop_eng}, 2'b00);
    chk("post_reset_abort", abort_cnt[1:0], 2'b00);
    drain_all();

    // Randomised traffic.
    h_left = 0;
    for (int c = 0; c < 3000; c++) begin
      idle_inputs();
      n_sink = 2'($urandom);
      if (h_left == 0) begin
        if ($urandom % 2 == 0) begin n_sop = 1'b1; n_val = 1'b1; end
      end else if ($urandom % 4 != 0) begin
        n_val = 1'b1;
        n_sop = ($urandom % 8 == 0);
        n_eop = (h_left == 1);
      end
      if (m_ord.size() > 0 && m_ord[0].done && $urandom % 3 == 0) begin
        n_sv[m_ord[0].eng] = 1'b1;
        n_se[m_ord[0].eng] = 1'($urandom);
      end
      step();
      if (last_acc) h_left = $urandom_range(7, 1);
      else if (m_st != 1) h_left = 0;
      else if (n_val) h_left--;
    end
    while (m_st == 1) begin idle_inputs(); n_val = 1'b1; n_eop = 1'b1; step(); end
    drain_all();
    idle_inputs(); step();
    sample_now();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
